serial_sink: RTL and testbench
==============================

Name: serial_sink

Overview:
- Receive-side endpoint of the node serial link, and the counterpart of serial_source / tx.
- Deserializes one-line serial frames carrying a destination address and checks each address against NODE_ID.
- Counts delivered packets and misrouted or framing-error packets.
- Drives busy back to the upstream transmitter while a frame is being received or consumed.

Parameters:
- NODE_ID, 0, identity of this node; received addresses are compared to NODE_ID[`ADDR_SZ-1:0].
- HOLD_CYCLES, 2, consume time: number of cycles busy stays high after a frame completes (legal range 0..255).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial line from upstream tx; idles low.
- busy  output  1  backpressure to upstream tx.
- clr_counts  input  1  synchronous clear of both counters.
- rx_valid  output  1  one-cycle pulse: a frame was accepted.
- rx_data  output  `ADDR_SZ  address of the last accepted frame.
- pkt_count  output  16  frames accepted with address == NODE_ID.
- err_count  output  8  misrouted frames plus framing-error frames.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset sampled high at posedge clk).
- Reset values: busy=0, rx_valid=0, rx_data=0, pkt_count=0, err_count=0; shift register and bit counter=0; state=IDLE. Reset mid-frame abandons the frame with no count update.
- Frame format, one bit per clk: start bit (1), then `ADDR_SZ data bits MSB first, then stop bit (0). The line idles at 0.
- FSM states: IDLE, SHIFT, STOP, HOLD.
- IDLE:
  - serial_in==1 -> SHIFT; busy=1 from the next cycle; bit counter=0.
  - serial_in==0 -> stay in IDLE.
- SHIFT: shift serial_in into the LSB of the shift register each cycle. After `ADDR_SZ bits -> STOP.
- STOP:
  - serial_in==0 -> frame good. rx_data<=shift register and rx_valid<=1 for one cycle.
    - Address == NODE_ID: pkt_count+1.
    - Otherwise: err_count+1.
  - serial_in==1 -> framing error: err_count+1, rx_valid stays 0, rx_data unchanged.
  - Either case: -> HOLD with hold counter=HOLD_CYCLES. If HOLD_CYCLES==0, go straight to IDLE and drop busy the next cycle.
- HOLD: busy=1; decrement the counter; at 0 -> IDLE and busy=0. serial_in is ignored in HOLD; a start bit there is not detected.
- Latency: rx_valid asserts 2+`ADDR_SZ cycles after the cycle in which the start bit is sampled.
- busy timing: high from the cycle after start-bit detection through the last HOLD cycle, inclusive.
- Counter widths: both counters saturate at all-ones and never wrap.
- clr_counts:
  - Has priority over an increment in the same cycle; the counter ends at 0 and that event is lost.
  - Does not affect the FSM, rx_valid or rx_data.
- Back-to-back frames: a start bit on the first IDLE cycle after HOLD is accepted.

Optional Feature:
- Macro: SINK_PARITY_EN.
- When defined:
  - The frame carries one even-parity bit between the last data bit and the stop bit. The parity bit makes the XOR of data+parity equal 0.
  - FSM gains a PARITY state between SHIFT and STOP.
  - Parity mismatch: err_count+1, rx_valid suppressed, then the normal STOP/HOLD sequence runs.
  - Latency becomes 3+`ADDR_SZ cycles. The upstream tx must be built with the matching option.
- When undefined: no parity bit, no PARITY state, frame as above.

Test Plan (`ADDR_SZ=4, NODE_ID=5, HOLD_CYCLES=2, macro off unless stated):
- Reset, line at 0 for 20 cycles -> busy=0, rx_valid never pulses, both counters 0.
- Send start, data 0101, stop 0 -> rx_valid pulses once, 6 cycles after the start bit is sampled; rx_data=5, pkt_count=1, err_count=0. busy is high for 1+4+1+2 cycles, then low.
- Send data 0011 with stop 0, then data 0101 with stop=1 -> rx_data=3, err_count=2, pkt_count=0. Only one rx_valid pulse is seen.
- Send 3 back-to-back frames of address 5, each start bit on the first cycle busy is low -> pkt_count=3. A start bit injected during HOLD is ignored, with no extra count.
- Hold clr_counts high in the exact STOP cycle of a good address-5 frame -> pkt_count=0 after the cycle, rx_valid still pulses, rx_data=5. Also: assert reset during SHIFT -> counters unchanged and busy=0 the next cycle.
- SINK_PARITY_EN defined:
  - data 0101 + parity 0 + stop 0 -> pkt_count=1.
  - data 0101 + parity 1 + stop 0 -> err_count=1, no rx_valid.

Source files
------------

// File: rtl/serial_sink_if.sv
// serial_sink_if: one-line serial link between an upstream transmitter and serial_sink.
//   serial_in : data line driven by the transmitter, idles low
//   busy      : backpressure from the receiver; a new frame may start only while low
// Modports: master = transmitter side, slave = receiver side.
// Frame address width comes from the ADDR_SZ macro (defaults to 4 when not set).
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

interface serial_sink_if;
  logic serial_in;
  logic busy;

  modport master (output serial_in, input busy);
  modport slave  (input serial_in, output busy);
endinterface

// File: rtl/serial_sink.sv
// serial_sink: receive-side endpoint of the node serial link.
// Deserializes frames {start=1, ADDR_SZ address bits MSB first, [parity], stop=0},
// compares the address with NODE_ID, and keeps saturating delivered / error counters.
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   link       : serial_sink_if.slave (serial_in in, busy out)
//   clr_counts : synchronous clear of both counters (wins over a same-cycle increment)
//   rx_valid   : one-cycle pulse when a frame is accepted
//   rx_data    : address of the last accepted frame
//   pkt_count  : frames accepted with address == NODE_ID
//   err_count  : misrouted frames plus framing / parity error frames
// Build option: define SINK_PARITY_EN to expect an even-parity bit before the stop bit.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module serial_sink #(
  parameter int unsigned NODE_ID     = 0,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  serial_sink_if.slave        link,
  input  logic                clr_counts,
  output logic                rx_valid,
  output logic [`ADDR_SZ-1:0] rx_data,
  output logic [15:0]         pkt_count,
  output logic [7:0]          err_count
);

  localparam int unsigned AW = `ADDR_SZ;
  localparam logic [AW-1:0] NodeAddr = AW'(NODE_ID);
  localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES);
  localparam logic [7:0] LastBit = 8'(AW - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StShift  = 3'd1;
  localparam logic [2:0] StStop   = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
`ifdef SINK_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          rx_valid_q, rx_valid_d;
  logic [AW-1:0] rx_data_q, rx_data_d;
  logic [15:0]   pkt_q;
  logic [7:0]    err_q;
  logic          pkt_inc, err_inc;
  logic          frame_ok;
`ifdef SINK_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;
`ifdef SINK_PARITY_EN
    par_err_d  = par_err_q;
    frame_ok   = ~link.serial_in & ~par_err_q;
`else
    frame_ok   = ~link.serial_in;
`endif
    case (state_q)
      StIdle: begin
        if (link.serial_in) begin
          state_d   = StShift;
          busy_d    = 1'b1;
          bit_cnt_d = 8'd0;
        end
      end
      StShift: begin
        // Truncating concat keeps this legal for a 1-bit address too.
        shift_d   = AW'({shift_q, link.serial_in});
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == LastBit) begin
`ifdef SINK_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef SINK_PARITY_EN
      StParity: begin
        // Even parity: XOR over data and parity bit must be zero.
        par_err_d = ^{shift_q, link.serial_in};
        state_d   = StStop;
      end
`endif
      StStop: begin
        if (frame_ok) begin
          rx_valid_d = 1'b1;
          rx_data_d  = shift_q;
          if (shift_q == NodeAddr) pkt_inc = 1'b1;
          else                     err_inc = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
        if (HoldInit == 8'd0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          state_d = StHold;
          hold_d  = HoldInit;
        end
      end
      StHold: begin
        // serial_in is deliberately ignored here; a start bit during HOLD is lost.
        if (hold_q == 8'd0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 8'd0;
      shift_q    <= '0;
      hold_q     <= 8'd0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef SINK_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
`ifdef SINK_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Saturating counters; a clear in the same cycle swallows the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= 16'd0;
      err_q <= 8'd0;
    end else if (clr_counts) begin
      pkt_q <= 16'd0;
      err_q <= 8'd0;
    end else begin
      if (pkt_inc && (pkt_q != '1)) pkt_q <= pkt_q + 16'd1;
      if (err_inc && (err_q != '1)) err_q <= err_q + 8'd1;
    end
  end

  assign link.busy = busy_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign pkt_count = pkt_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_serial_sink.sv
// tb_serial_sink: self-checking bench for serial_sink (NODE_ID=5, HOLD_CYCLES=2).
// Directed steps followed by random frames, checked against a frame-level reference model.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_serial_sink;

  localparam int unsigned AW   = `ADDR_SZ;
  localparam int unsigned NODE = 5;
  localparam int unsigned HOLD = 2;
`ifdef SINK_PARITY_EN
  localparam int unsigned PBIT = 1;
`else
  localparam int unsigned PBIT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr_counts = 1'b0;
  logic          rx_valid;
  logic [AW-1:0] rx_data;
  logic [15:0]   pkt_count;
  logic [7:0]    err_count;

  serial_sink_if link ();

  serial_sink #(.NODE_ID(NODE), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .link      (link),
    .clr_counts(clr_counts),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rv_pulses = 0;

  // Reference model state.
  int unsigned   exp_pkt = 0;
  int unsigned   exp_err = 0;
  logic [AW-1:0] exp_data = '0;

  always @(negedge clk) if (rx_valid === 1'b1) rv_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    link.serial_in = 1'b0;
    clr_counts = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    exp_data = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (link.busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check("wait_idle_bound", 32'(n < 60), 32'd1);
  endtask

  // Sends one frame starting on the first idle cycle; updates the model and checks outputs.
  task automatic send_frame(input logic [AW-1:0] addr, input logic stop, input logic par_flip,
                            input logic clr_at_stop);
    logic good;
    int   p0;
    wait_idle();
    p0 = rv_pulses;
    link.serial_in = 1'b1;
    tick();
    check("busy_after_start", 32'(link.busy), 32'd1);
    for (int i = AW - 1; i >= 0; i--) begin
      link.serial_in = addr[i];
      tick();
    end
`ifdef SINK_PARITY_EN
    link.serial_in = (^addr) ^ par_flip;
    tick();
`endif
    check("rx_valid_early", 32'(rx_valid), 32'd0);
    link.serial_in = stop;
    clr_counts = clr_at_stop;
    tick();
    link.serial_in = 1'b0;
    clr_counts = 1'b0;

    good = (stop == 1'b0) && (PBIT == 0 || par_flip == 1'b0);
    if (good) exp_data = addr;
    if (clr_at_stop) begin
      exp_pkt = 0;
      exp_err = 0;
    end else if (good && addr == AW'(NODE)) begin
      if (exp_pkt < 65535) exp_pkt++;
    end else begin
      if (exp_err < 255) exp_err++;
    end

    check("rx_valid_latency", 32'(rx_valid), 32'(good));
    check("busy_at_hold", 32'(link.busy), 32'(HOLD != 0));
    check("rx_data", 32'(rx_data), 32'(exp_data));
    check("pkt_count", 32'(pkt_count), exp_pkt);
    check("err_count", 32'(err_count), exp_err);
    tick();
    check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
    check("rx_pulse_count", 32'(rv_pulses - p0), 32'(good));
  endtask

  initial begin
    int p0;
    int n;
    logic [AW-1:0] a;
    logic s, pf, cl;

    link.serial_in = 1'b0;

    // Reset and idle line.
    do_reset();
    p0 = rv_pulses;
    for (int i = 0; i < 20; i++) tick();
    check("idle_busy", 32'(link.busy), 32'd0);
    check("idle_pulses", 32'(rv_pulses - p0), 32'd0);
    check("idle_pkt", 32'(pkt_count), 32'd0);
    check("idle_err", 32'(err_count), 32'd0);
    check("idle_rx_data", 32'(rx_data), 32'd0);

    // Single good frame to this node, plus busy duration.
    send_frame(AW'(NODE), 1'b0, 1'b0, 1'b0);
    n = 0;
    while (link.busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    // Samples already seen high: start cycle through the cycle after the post-stop tick.
    check("busy_length", 32'(n + AW + PBIT + 2), 32'(1 + AW + PBIT + 1 + HOLD));

    // Misrouted frame, then a framing error.
    do_reset();
    p0 = rv_pulses;
    send_frame(AW'(3), 1'b0, 1'b0, 1'b0);
    send_frame(AW'(NODE), 1'b1, 1'b0, 1'b0);
    check("err_pair_data", 32'(rx_data), 32'd3);
    check("err_pair_err", 32'(err_count), 32'd2);
    check("err_pair_pkt", 32'(pkt_count), 32'd0);
    check("err_pair_pulses", 32'(rv_pulses - p0), 32'd1);

    // Back-to-back frames, then a start bit injected during HOLD.
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(AW'(NODE), 1'b0, 1'b0, 1'b0);
    check("b2b_pkt", 32'(pkt_count), 32'd3);
    link.serial_in = 1'b1;
    tick();
    link.serial_in = 1'b0;
    p0 = rv_pulses;
    for (int i = 0; i < 14; i++) tick();
    check("hold_start_busy", 32'(link.busy), 32'd0);
    check("hold_start_pkt", 32'(pkt_count), 32'd3);
    check("hold_start_err", 32'(err_count), 32'd0);
    check("hold_start_pulses", 32'(rv_pulses - p0), 32'd0);

    // Clear in the STOP cycle of a good frame.
    send_frame(AW'(NODE), 1'b0, 1'b0, 1'b1);
    check("clr_stop_pkt", 32'(pkt_count), 32'd0);
    check("clr_stop_data", 32'(rx_data), 32'(NODE));

    // Reset in the middle of SHIFT abandons the frame.
    wait_idle();
    link.serial_in = 1'b1;
    tick();
    link.serial_in = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_data = '0;
    check("mid_reset_busy", 32'(link.busy), 32'd0);
    check("mid_reset_pkt", 32'(pkt_count), 32'd0);
    check("mid_reset_err", 32'(err_count), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("mid_reset_idle", 32'(link.busy), 32'd0);
    send_frame(AW'(NODE), 1'b0, 1'b0, 1'b0);
    check("post_reset_pkt", 32'(pkt_count), 32'd1);

`ifdef SINK_PARITY_EN
    // Parity good and parity bad.
    do_reset();
    send_frame(AW'(NODE), 1'b0, 1'b0, 1'b0);
    check("par_good_pkt", 32'(pkt_count), 32'd1);
    do_reset();
    p0 = rv_pulses;
    send_frame(AW'(NODE), 1'b0, 1'b1, 1'b0);
    check("par_bad_err", 32'(err_count), 32'd1);
    check("par_bad_pulses", 32'(rv_pulses - p0), 32'd0);
`endif

    // err_count saturates at 255.
    do_reset();
    for (int i = 0; i < 260; i++) send_frame(AW'($urandom_range(0, (1 << AW) - 1)), 1'b1, 1'b0,
                                             1'b0);
    check("err_saturate", 32'(err_count), 32'd255);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      a  = ($urandom_range(0, 1) == 0) ? AW'(NODE) : AW'($urandom_range(0, (1 << AW) - 1));
      s  = ($urandom_range(0, 7) == 0);
      pf = (PBIT != 0) && ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 15) == 0);
      n  = $urandom_range(0, 3);
      wait_idle();
      for (int k = 0; k < n; k++) tick();
      send_frame(a, s, pf, cl);
    end
    check("rand_final_pkt", 32'(pkt_count), exp_pkt);
    check("rand_final_err", 32'(err_count), exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
